// File: rtl/weight_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | weight_loader_pkg: FSM encoding, layer indices and default network  |
// | dimensions shared by the weight loader and the network top.         |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package weight_loader_pkg;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_load_l0 = 3'd1;
    localparam logic [2:0] c_st_load_l1 = 3'd2;
    localparam logic [2:0] c_st_check   = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    localparam logic LAYER0 = 1'b0;
    localparam logic LAYER1 = 1'b1;

    localparam int c_def_bits_per_word = 8;
    localparam int c_def_l0_n          = 3;
    localparam int c_def_l0_m          = 2;
    localparam int c_def_l1_n          = 3;
    localparam int c_def_l1_m          = 1;
    localparam int c_def_clog2_n       = 2;
    localparam int c_def_clog2_m       = 2;

    function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] word);
        return sum + word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_loader_addr_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | weight_addr_counter: row/column address counter, column fastest,    |
// | with run-time limits and a terminal-count flag.                     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module weight_addr_counter #(
    parameter int N_BITS = 2,
    parameter int M_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic [N_BITS-1:0] i_n_last,
    input  logic [M_BITS-1:0] i_m_last,
    output logic [N_BITS-1:0] o_n,
    output logic [M_BITS-1:0] o_m,
    output logic              o_terminal
);

    logic [N_BITS-1:0] r_n;
    logic [M_BITS-1:0] r_m;
    logic              w_terminal;

    assign w_terminal = (r_n == i_n_last) && (r_m == i_m_last);

    // Wrapping to zero on terminal count hands a clean origin to the next layer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n <= '0;
            r_m <= '0;
        end else if (i_clear) begin
            r_n <= '0;
            r_m <= '0;
        end else if (i_advance) begin
            if (w_terminal) begin
                r_n <= '0;
                r_m <= '0;
            end else if (r_m == i_m_last) begin
                r_m <= '0;
                r_n <= r_n + 1'b1;
            end else begin
                r_m <= r_m + 1'b1;
            end
        end
    end

    assign o_n        = r_n;
    assign o_m        = r_m;
    assign o_terminal = w_terminal;

endmodule
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | weight_loader: streams signed weight words into the two-layer       |
// | network weight memory. Optional WEIGHT_LOADER_CHECKSUM_EN adds a    |
// | trailing mod-256 checksum word. Rev 1.0                             |
// +--------------------------------------------------------------------+
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int BITS_PER_WORD       = c_def_bits_per_word,
    parameter int L0_N                = c_def_l0_n,
    parameter int L0_M                = c_def_l0_m,
    parameter int L1_N                = c_def_l1_n,
    parameter int L1_M                = c_def_l1_m,
    parameter int CLOG2_MAX_WEIGHTS_N = c_def_clog2_n,
    parameter int CLOG2_MAX_WEIGHTS_M = c_def_clog2_m
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic signed [BITS_PER_WORD-1:0]       s_data,
    output logic                                  weights_en,
    output logic                                  weights_layer_address,
    output logic [CLOG2_MAX_WEIGHTS_N-1:0]        weights_n_address,
    output logic [CLOG2_MAX_WEIGHTS_M-1:0]        weights_m_address,
    output logic signed [BITS_PER_WORD-1:0]       weights_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error
);

    localparam logic [CLOG2_MAX_WEIGHTS_N-1:0] c_l0_n_last = CLOG2_MAX_WEIGHTS_N'(L0_N - 1);
    localparam logic [CLOG2_MAX_WEIGHTS_M-1:0] c_l0_m_last = CLOG2_MAX_WEIGHTS_M'(L0_M - 1);
    localparam logic [CLOG2_MAX_WEIGHTS_N-1:0] c_l1_n_last = CLOG2_MAX_WEIGHTS_N'(L1_N - 1);
    localparam logic [CLOG2_MAX_WEIGHTS_M-1:0] c_l1_m_last = CLOG2_MAX_WEIGHTS_M'(L1_M - 1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_st_after_l1 = c_st_check;
`else
    localparam logic [2:0] c_st_after_l1 = c_st_done;
`endif

    logic [2:0]                     r_state;
    logic [2:0]                     w_state_next;
    logic                           w_start;
    logic                           w_accept;
    logic                           w_load_beat;
    logic                           w_layer;
    logic [CLOG2_MAX_WEIGHTS_N-1:0] w_n_last;
    logic [CLOG2_MAX_WEIGHTS_M-1:0] w_m_last;
    logic [CLOG2_MAX_WEIGHTS_N-1:0] w_n;
    logic [CLOG2_MAX_WEIGHTS_M-1:0] w_m;
    logic                           w_terminal;

    logic                           r_wen;
    logic                           r_layer;
    logic [CLOG2_MAX_WEIGHTS_N-1:0] r_n;
    logic [CLOG2_MAX_WEIGHTS_M-1:0] r_m;
    logic signed [BITS_PER_WORD-1:0] r_data;
    logic                           r_done;

    assign w_start     = (r_state == c_st_idle) && start;
    assign s_ready     = (r_state == c_st_load_l0) || (r_state == c_st_load_l1) ||
                         (r_state == c_st_check);
    assign w_accept    = s_valid && s_ready;
    assign w_load_beat = w_accept && ((r_state == c_st_load_l0) || (r_state == c_st_load_l1));
    assign w_layer     = (r_state == c_st_load_l1) ? LAYER1 : LAYER0;
    assign w_n_last    = (w_layer == LAYER1) ? c_l1_n_last : c_l0_n_last;
    assign w_m_last    = (w_layer == LAYER1) ? c_l1_m_last : c_l0_m_last;
    assign busy        = (r_state != c_st_idle) && (r_state != c_st_done);

    weight_addr_counter #(
        .N_BITS (CLOG2_MAX_WEIGHTS_N),
        .M_BITS (CLOG2_MAX_WEIGHTS_M)
    ) u_addr_counter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start),
        .i_advance  (w_load_beat),
        .i_n_last   (w_n_last),
        .i_m_last   (w_m_last),
        .o_n        (w_n),
        .o_m        (w_m),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:    if (start) w_state_next = c_st_load_l0;
            c_st_load_l0: if (w_load_beat && w_terminal) w_state_next = c_st_load_l1;
            c_st_load_l1: if (w_load_beat && w_terminal) w_state_next = c_st_after_l1;
            c_st_check:   if (w_accept) w_state_next = c_st_done;
            c_st_done:    w_state_next = c_st_idle;
            default:      w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Write port is a registered copy of the accepted beat; async reset drops a pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_layer <= 1'b0;
            r_n     <= '0;
            r_m     <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_wen  <= w_load_beat;
            r_done <= (r_state == c_st_done);
            if (w_load_beat) begin
                r_layer <= w_layer;
                r_n     <= w_n;
                r_m     <= w_m;
                r_data  <= s_data;
            end
        end
    end

    assign weights_en            = r_wen;
    assign weights_layer_address = r_layer;
    assign weights_n_address     = r_n;
    assign weights_m_address     = r_m;
    assign weights_data          = r_data;
    assign done                  = r_done;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_error;
    logic [7:0] w_word8;

    assign w_word8 = 8'($signed(s_data));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum   <= 8'd0;
            r_error <= 1'b0;
        end else if (w_start) begin
            r_sum   <= 8'd0;
            r_error <= 1'b0;
        end else if (w_load_beat) begin
            r_sum <= checksum_add(r_sum, w_word8);
        end else if ((r_state == c_st_check) && w_accept) begin
            r_error <= (checksum_add(r_sum, w_word8) != 8'd0);
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_weight_loader: directed self-checking bench for weight_loader.   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_weight_loader;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic signed [7:0] s_data;
    logic              weights_en;
    logic              weights_layer_address;
    logic [1:0]        weights_n_address;
    logic [1:0]        weights_m_address;
    logic signed [7:0] weights_data;
    logic              busy;
    logic              done;
    logic              error;

    weight_loader dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .s_valid               (s_valid),
        .s_ready               (s_ready),
        .s_data                (s_data),
        .weights_en            (weights_en),
        .weights_layer_address (weights_layer_address),
        .weights_n_address     (weights_n_address),
        .weights_m_address     (weights_m_address),
        .weights_data          (weights_data),
        .busy                  (busy),
        .done                  (done),
        .error                 (error)
    );

    always #5 clk = ~clk;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [12:0] rec [0:255];
    int wr_cnt      = 0;
    int done_cnt    = 0;
    int last_wr_cyc = 0;
    int done_cyc    = 0;
    logic [7:0] stim [0:8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (weights_en) begin
            if (wr_cnt < 256)
                rec[wr_cnt] = {weights_layer_address, weights_n_address, weights_m_address, weights_data};
            wr_cnt      = wr_cnt + 1;
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    function automatic logic [12:0] exp_entry(input int i);
        logic [1:0] n;
        logic [1:0] m;
        logic       l;
        l = (i >= 6);
        n = (i < 6) ? 2'(i / 2) : 2'(i - 6);
        m = (i < 6) ? 2'(i % 2) : 2'd0;
        return {l, n, m, stim[i]};
    endfunction

    function automatic logic [7:0] good_chk();
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 9; i++) s = s + stim[i];
        return 8'd0 - s;
    endfunction

    task automatic drive_word(input logic [7:0] w);
        int  t;
        bit  got;
        t   = 0;
        got = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        while (!got && t < 50) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            #1;
            t++;
        end
        s_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout: word %h not accepted, got ready=%0b required ready=1", w, got);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full load; start_at >= 0 pulses start before that word index. exp_err is the error flag the bench expects.
    task automatic run_seq(input bit gaps, input int start_at, input logic [7:0] chk, output logic exp_err);
        int         d0;
        int         t;
        logic [7:0] s;
        d0 = done_cnt;
        s  = chk;
        do_start();
        for (int i = 0; i < 9; i++) begin
            if (i == start_at) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            drive_word(stim[i]);
            s = s + stim[i];
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
        if (CHK_ON) drive_word(chk);
        exp_err = CHK_ON && (s != 8'd0);
        t = 0;
        while (done_cnt == d0 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'sd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({s_ready, weights_en, weights_layer_address, weights_n_address, weights_m_address,
             weights_data, busy, done, error} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b rdy=%b busy=%b done=%b err=%b data=%h required all 0",
                     weights_en, s_ready, busy, done, error, weights_data);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({busy, s_ready} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b required 0 0", busy, s_ready);
        end
    endtask

    task automatic test_back_to_back();
        int   base;
        int   d0;
        logic ee;
        for (int i = 0; i < 9; i++) stim[i] = 8'(i + 1);
        base = wr_cnt;
        d0   = done_cnt;
        run_seq(1'b0, -1, good_chk(), ee);
        total++;
        if (wr_cnt - base != 9) begin
            bad++;
            $display("FAIL b2b_count: got %0d writes required 9", wr_cnt - base);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rec[base + i] !== exp_entry(i)) begin
                bad++;
                $display("FAIL b2b_write%0d: got %h required %h", i, rec[base + i], exp_entry(i));
            end
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d required 1", done_cnt - d0);
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        total++;
        if (!(done_cyc > last_wr_cyc + 1)) begin
            bad++;
            $display("FAIL b2b_done_timing: got done at %0d last write at %0d required done after check word", done_cyc, last_wr_cyc);
        end
`else
        total++;
        if (done_cyc != last_wr_cyc + 1) begin
            bad++;
            $display("FAIL b2b_done_timing: got done at %0d required %0d", done_cyc, last_wr_cyc + 1);
        end
`endif
        total++;
        if ({busy, error} !== {1'b0, ee}) begin
            bad++;
            $display("FAIL b2b_end_state: got busy=%b err=%b required 0 %b", busy, error, ee);
        end
    endtask

    task automatic test_gaps();
        int   base;
        int   d0;
        logic ee;
        for (int i = 0; i < 9; i++) stim[i] = 8'(i + 1);
        base = wr_cnt;
        d0   = done_cnt;
        run_seq(1'b1, -1, good_chk(), ee);
        total++;
        if (wr_cnt - base != 9) begin
            bad++;
            $display("FAIL gap_count: got %0d writes required 9", wr_cnt - base);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rec[base + i] !== exp_entry(i)) begin
                bad++;
                $display("FAIL gap_write%0d: got %h required %h", i, rec[base + i], exp_entry(i));
            end
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL gap_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_start_ignored();
        int   base;
        int   d0;
        logic ee;
        for (int i = 0; i < 9; i++) stim[i] = 8'(8'h20 + i);
        base = wr_cnt;
        d0   = done_cnt;
        run_seq(1'b0, 7, good_chk(), ee);
        total++;
        if (wr_cnt - base != 9) begin
            bad++;
            $display("FAIL restart_count: got %0d writes required 9", wr_cnt - base);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rec[base + i] !== exp_entry(i)) begin
                bad++;
                $display("FAIL restart_write%0d: got %h required %h", i, rec[base + i], exp_entry(i));
            end
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL restart_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int   base;
        int   d0;
        logic ee;
        for (int i = 0; i < 9; i++) stim[i] = 8'(i + 1);
        base = wr_cnt;
        d0   = done_cnt;
        do_start();
        for (int i = 0; i < 4; i++) drive_word(stim[i]);
        reset = 1'b1;
        #1;
        total++;
        if ({s_ready, weights_en, weights_layer_address, weights_n_address, weights_m_address,
             weights_data, busy, done, error} !== 18'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got en=%b rdy=%b busy=%b data=%h required all 0",
                     weights_en, s_ready, busy, weights_data);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (wr_cnt - base != 3) begin
            bad++;
            $display("FAIL midreset_dropped: got %0d writes required 3", wr_cnt - base);
        end
        total++;
        if (done_cnt != d0) begin
            bad++;
            $display("FAIL midreset_no_done: got %0d done pulses required 0", done_cnt - d0);
        end
        @(posedge clk);
        #1;
        base = wr_cnt;
        run_seq(1'b0, -1, good_chk(), ee);
        total++;
        if (wr_cnt - base != 9) begin
            bad++;
            $display("FAIL midreset_reload_count: got %0d writes required 9", wr_cnt - base);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rec[base + i] !== exp_entry(i)) begin
                bad++;
                $display("FAIL midreset_write%0d: got %h required %h", i, rec[base + i], exp_entry(i));
            end
        end
    endtask

    task automatic test_extremes();
        int   base;
        logic ee;
        stim[0] = 8'h80;
        stim[1] = 8'h7F;
        for (int i = 2; i < 9; i++) stim[i] = 8'(8'hF0 + i);
        base = wr_cnt;
        run_seq(1'b0, -1, good_chk(), ee);
        total++;
        if (rec[base] !== {1'b0, 2'd0, 2'd0, 8'h80}) begin
            bad++;
            $display("FAIL extreme_neg: got %h required %h", rec[base], {1'b0, 2'd0, 2'd0, 8'h80});
        end
        total++;
        if (rec[base + 1] !== {1'b0, 2'd0, 2'd1, 8'h7F}) begin
            bad++;
            $display("FAIL extreme_pos: got %h required %h", rec[base + 1], {1'b0, 2'd0, 2'd1, 8'h7F});
        end
        total++;
        if (rec[base + 8] !== exp_entry(8)) begin
            bad++;
            $display("FAIL extreme_last: got %h required %h", rec[base + 8], exp_entry(8));
        end
    endtask

    task automatic test_checksum();
        logic ee;
        for (int i = 0; i < 9; i++) stim[i] = 8'(i + 1);
        run_seq(1'b0, -1, 8'hD3, ee);
        total++;
        if (error !== ee) begin
            bad++;
            $display("FAIL chk_good: got error=%b required %b", error, ee);
        end
        run_seq(1'b0, -1, 8'h00, ee);
        total++;
        if (error !== ee) begin
            bad++;
            $display("FAIL chk_bad: got error=%b required %b", error, ee);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (error !== ee) begin
            bad++;
            $display("FAIL chk_sticky: got error=%b required %b", error, ee);
        end
        run_seq(1'b0, -1, good_chk(), ee);
        total++;
        if (error !== ee) begin
            bad++;
            $display("FAIL chk_cleared: got error=%b required %b", error, ee);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_start_ignored();
        test_reset_mid();
        test_extremes();
        test_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
